hazard_ctrl: RTL and testbench

Hazard detection and pipeline-control block for the 5-stage processor, sitting in Decode beside the EX-stage forwarding unit.
- Detects load-use hazards that forwarding cannot resolve and inserts one bubble.
- Flushes on taken branches and sequences the multi-cycle RET/RTI PC-pop window.
- Freezes the whole pipeline while data memory is busy.
- Drives the PC, IF/ID and ID/EX register enables and flushes, and keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_ctrl_pkg.sv | 21 ++
 rtl/hazard_ctrl_if.sv | 33 +++
 rtl/hazard_ctrl_sat_counter.sv | 19 +
 rtl/hazard_ctrl.sv | 100 ++++++++++
 tb/tb_hazard_ctrl.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the Decode-stage hazard/pipeline control block.
package hazard_ctrl_pkg;

    localparam int ADDR_W = 3;
    localparam int CTRL_W = 8;

    // Control word the ID/EX register loads when a bubble is inserted.
    localparam logic [CTRL_W-1:0] IDEX_NOP_CTRL = '0;

    typedef enum logic {
        RUN      = 1'b0,
        RET_WAIT = 1'b1
    } hz_state_t;

    function automatic logic addr_hit(input logic used,
                                      input logic [ADDR_W-1:0] a,
                                      input logic [ADDR_W-1:0] b);
        return used && (a == b);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode/Execute status in, pipeline register controls out.
interface hazard_ctrl_if #(parameter int CNT_W = 16);
    import hazard_ctrl_pkg::*;

    logic [ADDR_W-1:0] id_src_addr;
    logic              id_src_used;
    logic [ADDR_W-1:0] id_dst_addr;
    logic              id_dst_used;
    logic [ADDR_W-1:0] ex_dst_addr;
    logic              ex_mem_read;
    logic              ex_branch_taken;
    logic              ex_ret;
    logic              mem_busy;
    logic              pc_we;
    logic              ifid_we;
    logic              ifid_flush;
    logic              idex_bubble;
    logic              ret_pending;
    logic [CNT_W-1:0]  stall_cycles;

    modport master (
        output id_src_addr, id_src_used, id_dst_addr, id_dst_used,
               ex_dst_addr, ex_mem_read, ex_branch_taken, ex_ret, mem_busy,
        input  pc_we, ifid_we, ifid_flush, idex_bubble, ret_pending, stall_cycles
    );

    modport slave (
        input  id_src_addr, id_src_used, id_dst_addr, id_dst_used,
               ex_dst_addr, ex_mem_read, ex_branch_taken, ex_ret, mem_busy,
        output pc_we, ifid_we, ifid_flush, idex_bubble, ret_pending, stall_cycles
    );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Enable-driven saturating up-counter with asynchronous active-high reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall, branch flush, RET/RTI PC-pop window and memory freeze control.
// state    | meaning
// RUN      | normal issue; load-use, branch and ret detection active
// RET_WAIT | front end held while the return PC is popped; ret_cnt counts down
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int RET_CYCLES = 3,
    parameter int CNT_W      = 16
) (
    input logic          clk,
    input logic          rst,
    hazard_ctrl_if.slave hz
);

    // RET_WAIT spans RET_CYCLES+1 cycles: RET_CYCLES held cycles plus the pop cycle.
    localparam logic [3:0] RET_INIT = 4'(RET_CYCLES);

    hz_state_t  state;
    logic [3:0] ret_cnt;
    logic       lu;
    logic       pc_we_c;
    logic [CNT_W-1:0] stall_cnt;

    assign lu = hz.ex_mem_read &
                (addr_hit(hz.id_src_used, hz.id_src_addr, hz.ex_dst_addr) |
                 addr_hit(hz.id_dst_used, hz.id_dst_addr, hz.ex_dst_addr));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            ret_cnt <= '0;
        end else if (!hz.mem_busy) begin
            case (state)
                RUN: begin
                    if (hz.ex_ret) begin
                        state   <= RET_WAIT;
                        ret_cnt <= RET_INIT;
                    end
                end
                RET_WAIT: begin
                    if (ret_cnt == 4'd0) begin
                        state <= RUN;
                    end else begin
                        ret_cnt <= ret_cnt - 4'd1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    always_comb begin
        pc_we_c        = 1'b0;
        hz.ifid_we     = 1'b0;
        hz.ifid_flush  = 1'b0;
        hz.idex_bubble = 1'b0;
        hz.ret_pending = 1'b0;
        if (rst) begin
            hz.ifid_flush  = 1'b1;
            hz.idex_bubble = 1'b1;
        end else begin
            hz.ret_pending = (state == RET_WAIT);
            if (hz.mem_busy) begin
                pc_we_c = 1'b0;
            end else if (state == RET_WAIT) begin
                hz.ifid_we     = 1'b1;
                hz.ifid_flush  = 1'b1;
                hz.idex_bubble = 1'b1;
                pc_we_c        = (ret_cnt == 4'd0);
            end else if (hz.ex_ret) begin
                hz.ifid_we     = 1'b1;
                hz.ifid_flush  = 1'b1;
                hz.idex_bubble = 1'b1;
            end else if (hz.ex_branch_taken) begin
                pc_we_c        = 1'b1;
                hz.ifid_we     = 1'b1;
                hz.ifid_flush  = 1'b1;
                hz.idex_bubble = 1'b1;
            end else if (lu) begin
                hz.idex_bubble = 1'b1;
            end else begin
                pc_we_c    = 1'b1;
                hz.ifid_we = 1'b1;
            end
        end
    end

    assign hz.pc_we = pc_we_c;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (~pc_we_c),
        .count (stall_cnt)
    );

    assign hz.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a queue of expected per-cycle control outputs.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int CNT_W = 4;
    localparam int RET_CYCLES = 3;

    typedef struct {
        logic             pc_we;
        logic             ifid_we;
        logic             ifid_flush;
        logic             idex_bubble;
        logic             ret_pending;
        logic             rp_chk;
        logic [CNT_W-1:0] stall;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [CNT_W-1:0] exp_cnt = '0;
    exp_t sb[$];

    hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    hazard_ctrl #(.RET_CYCLES(RET_CYCLES), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic mr, input logic [2:0] xd,
                       input logic [2:0] sa, input logic su,
                       input logic [2:0] da, input logic du,
                       input logic br, input logic rt, input logic mb);
        hz.ex_mem_read     = mr;
        hz.ex_dst_addr     = xd;
        hz.id_src_addr     = sa;
        hz.id_src_used     = su;
        hz.id_dst_addr     = da;
        hz.id_dst_used     = du;
        hz.ex_branch_taken = br;
        hz.ex_ret          = rt;
        hz.mem_busy        = mb;
    endtask

    // Push the expectation for the current cycle, sample mid-cycle, then advance.
    task automatic cyc(input logic pc, input logic iw, input logic fl,
                       input logic bb, input logic rp, input logic rpc);
        exp_t e;
        e.pc_we = pc; e.ifid_we = iw; e.ifid_flush = fl; e.idex_bubble = bb;
        e.ret_pending = rp; e.rp_chk = rpc; e.stall = exp_cnt;
        sb.push_back(e);
        if (!rst && !pc && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
        #2;
        e = sb.pop_front();
        chk("pc_we", 8'(hz.pc_we), 8'(e.pc_we));
        chk("ifid_we", 8'(hz.ifid_we), 8'(e.ifid_we));
        chk("ifid_flush", 8'(hz.ifid_flush), 8'(e.ifid_flush));
        chk("idex_bubble", 8'(hz.idex_bubble), 8'(e.idex_bubble));
        if (e.rp_chk) chk("ret_pending", 8'(hz.ret_pending), 8'(e.ret_pending));
        chk("stall_cycles", 8'(hz.stall_cycles), 8'(e.stall));
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        // reset values
        cyc(0, 0, 1, 1, 0, 1);
        rst = 1'b0;

        cyc(1, 1, 0, 0, 0, 1);
        // load-use on src
        drv(1, 3, 3, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 1);
        drv(0, 3, 3, 1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 1);
        // same addresses but source not used
        drv(1, 3, 3, 0, 5, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 1);
        // load-use on second operand
        drv(1, 5, 3, 0, 5, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 1);
        // branch wins over load-use
        drv(1, 3, 3, 1, 0, 0, 1, 0, 0);
        cyc(1, 1, 1, 1, 0, 1);

        // RET window
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 1, 1, 1, 0, 1);
        drv(1, 3, 3, 1, 0, 0, 1, 1, 0);
        cyc(0, 1, 1, 1, 1, 1);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 1, 1, 1);
        cyc(0, 1, 1, 1, 1, 1);
        cyc(1, 1, 1, 1, 1, 1);
        cyc(1, 1, 0, 0, 0, 1);

        // RET window stretched by a two-cycle memory freeze
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 1, 1, 1, 0, 1);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 1, 1, 1);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 1, 1, 1);
        cyc(0, 1, 1, 1, 1, 1);
        cyc(1, 1, 1, 1, 1, 1);
        cyc(1, 1, 0, 0, 0, 1);

        // async reset mid RET_WAIT
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 1, 1, 1, 0, 1);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 1, 1, 1);
        #1;
        rst = 1'b1;
        exp_cnt = '0;
        cyc(0, 0, 1, 1, 0, 1);
        rst = 1'b0;
        cyc(1, 1, 0, 0, 0, 1);

        // saturation under a sustained load-use condition
        drv(1, 3, 3, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 1, 0, 1);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
